// File: rtl/mux_8to1.sv
// mux_8to1: single-bit 8-to-1 multiplexer, leaf primitive of the ALU mux tree.
//   y          = a[s]            (combinational, reset-independent)
//   sel_onehot = 8'b1 << s       (combinational decode)
//   y_q        = a[s] captured on a rising clk edge when in_valid=1, else held
//   out_valid  = in_valid delayed by one clock
// Optional feature macro: MUX8_SEL_CHECK_EN
//   Defined   -> an X/Z on s forces y=0, sel_onehot=0, sel_err=1 (y_q captures 0).
//   Undefined -> sel_err tied 0, plain a[s] semantics, no X-detection logic.
// Valid semantics: in_valid is a capture strobe with no back-pressure; every
// edge that sees in_valid=1 loads y_q, and out_valid reports that load on the
// following cycle. There is no ready signal because the block never stalls.
module mux_8to1 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [2:0] s,
  input  logic       in_valid,
  output logic       y,
  output logic [7:0] sel_onehot,
  output logic       sel_err,
  output logic       y_q,
  output logic       out_valid
);

  logic       w_y;
  logic [7:0] w_onehot;
  logic       w_sel_err;
  logic       r_y_q;
  logic       r_out_valid;

`ifdef MUX8_SEL_CHECK_EN
  // Select path with X/Z detection: an unknown select yields a safe all-zero result.
  always_comb begin
    w_y       = 1'b0;
    w_onehot  = 8'h00;
    w_sel_err = 1'b0;
    if ($isunknown(s)) begin
      w_sel_err = 1'b1;
    end else begin
      w_y      = a[s];
      w_onehot = 8'b1 << s;
    end
  end
`else
  // Plain select path: every 3-bit code is legal, no X-detection.
  always_comb begin
    w_y       = a[s];
    w_onehot  = 8'b1 << s;
    w_sel_err = 1'b0;
  end
`endif

  // Registered copy: capture on in_valid, hold otherwise; valid follows the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_y_q <= w_y;
      end
    end
  end

  assign y          = w_y;
  assign sel_onehot = w_onehot;
  assign sel_err    = w_sel_err;
  assign y_q        = r_y_q;
  assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_mux_8to1.sv
// Self-checking bench for mux_8to1: combinational select/decode, reset
// behaviour, registered capture/hold and mid-stream asynchronous reset.
module tb_mux_8to1;

  logic       clk;
  logic       clk_run;
  logic       rst_n;
  logic [7:0] a;
  logic [2:0] s;
  logic       in_valid;
  logic       y;
  logic [7:0] sel_onehot;
  logic       sel_err;
  logic       y_q;
  logic       out_valid;

  logic [8:0] exp_q[$];
  int         n_cmp;
  int         n_err;
  logic       model_yq;

  mux_8to1 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .s          (s),
    .in_valid   (in_valid),
    .y          (y),
    .sel_onehot (sel_onehot),
    .sel_err    (sel_err),
    .y_q        (y_q),
    .out_valid  (out_valid)
  );

  // Clock: idle until clk_run is set so combinational tests see no edges.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected value and compare it against an observation.
  task automatic pop_check(input string tag, input logic [8:0] obs);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %h expected queued value (queue empty)", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // Drive a/s with idle clock and check {sel_onehot, y} one time unit later.
  task automatic drive_comb(input logic [7:0] av, input logic [2:0] sv,
                            input logic [7:0] exp_oh, input logic exp_y, input string tag);
    a = av;
    s = sv;
    exp_q.push_back({exp_oh, exp_y});
    #1;
    pop_check(tag, {sel_onehot, y});
  endtask

  // One clocked cycle: drive at negedge, check {out_valid, y_q} after posedge.
  task automatic step(input logic [7:0] av, input logic [2:0] sv, input logic iv, input string tag);
    logic [7:0] tmp;
    @(negedge clk);
    a = av;
    s = sv;
    in_valid = iv;
    tmp = av;
    if (iv) model_yq = tmp[sv];
    exp_q.push_back({7'b0, iv, model_yq});
    @(posedge clk);
    #1;
    pop_check(tag, {7'b0, out_valid, y_q});
  endtask

  initial begin
    logic       y_tbl [8];
    logic [7:0] ra;
    logic [2:0] rs;
    n_cmp = 0;
    n_err = 0;
    y_tbl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    clk = 1'b0;
    clk_run = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 8'hFF;
    s = 3'd0;
    model_yq = 1'b0;

    // Reset held, no clock edge: registered outputs 0, y still live.
    #1;
    check("rst_yq", {8'b0, y_q}, 9'd0);
    check("rst_ov", {8'b0, out_valid}, 9'd0);
    check("rst_y", {8'b0, y}, 9'd1);

    // Exhaustive select with a=A5.
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_comb(8'hA5, 3'(i), 8'h01 << i, y_tbl[i], $sformatf("exh_s%0d", i));
      check($sformatf("exh_err_s%0d", i), {8'b0, sel_err}, 9'd0);
    end

    // Random {a,s} with idle clock and random reset level.
    for (int i = 0; i < 1024; i++) begin
      ra = 8'($urandom_range(0, 255));
      rs = 3'($urandom_range(0, 7));
      rst_n = 1'($urandom_range(0, 1));
      drive_comb(ra, rs, 8'h01 << rs, ra[rs], "rand");
    end

`ifdef MUX8_SEL_CHECK_EN
    // Unknown select.
    a = 8'hFF;
    s = 3'bx1x;
    #1;
    check("selx_y", {8'b0, y}, 9'd0);
    check("selx_oh", {1'b0, sel_onehot}, 9'd0);
    check("selx_err", {8'b0, sel_err}, 9'd1);
`endif

    // Registered path: clean reset, release, then start the clock.
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_yq = 1'b0;
    clk_run = 1'b1;

    step(8'h80, 3'd7, 1'b1, "cap_80_s7");
    step(8'h80, 3'd0, 1'b0, "hold_s0");
    step(8'h80, 3'd0, 1'b0, "hold2_s0");
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom_range(0, 255));
      rs = 3'($urandom_range(0, 7));
      step(ra, rs, 1'($urandom_range(0, 1)), "rand_reg");
    end
    step(8'h01, 3'd0, 1'b1, "cap_01_s0");

    // Mid-stream asynchronous reset between edges.
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    a = 8'h10;
    s = 3'd4;
    rst_n = 1'b0;
    #1;
    check("midrst_yq", {8'b0, y_q}, 9'd0);
    check("midrst_ov", {8'b0, out_valid}, 9'd0);
    check("midrst_y", {8'b0, y}, 9'd1);
    model_yq = 1'b0;
    // Capture attempted while reset held is lost.
    @(posedge clk);
    #1;
    check("rst_hold_yq", {8'b0, y_q}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'hFF, 3'd3, 1'b1, "post_rst_cap");
    step(8'h00, 3'd3, 1'b1, "post_rst_cap0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
